// File: rtl/apb5_arbiter.sv
// Two-requester APB5 arbiter: round-robin grant onto one APB5 requester interface.
// Optional wake-up output is built only when APB5_ARB_WAKEUP_EN is defined.
module apb5_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [1:0]                rq_valid,
  input  logic [2*ADDR_WIDTH-1:0]   rq_addr,
  input  logic [1:0]                rq_write,
  input  logic [2*DATA_WIDTH-1:0]   rq_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] rq_strb,
  input  logic [5:0]                rq_prot,
  input  logic [1:0]                rq_nse,
  output logic [1:0]                rq_done,
  output logic [DATA_WIDTH-1:0]     rq_rdata,
  output logic                      rq_slverr,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic                      pnse,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr,
  output logic                      pwakeup
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e state;
  logic   grant;
  logic   completing;
  logic   load_en;
  logic   load_idx;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [StrbWidth-1:0]  sel_strb;
  logic [2:0]            sel_prot;
  logic                  sel_write;
  logic                  sel_nse;

  assign completing = (state == StAccess) && pready;

  always_comb begin
    load_en  = 1'b0;
    load_idx = 1'b0;
    if (state == StIdle) begin
      load_en  = |rq_valid;
      load_idx = (rq_valid == 2'b11) ? ~grant : rq_valid[1];
    end else if (completing) begin
      load_en  = rq_valid[~grant];
      load_idx = ~grant;
    end
  end

  assign sel_addr  = load_idx ? rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rq_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = load_idx ? rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : rq_wdata[DATA_WIDTH-1:0];
  assign sel_strb  = load_idx ? rq_strb[2*StrbWidth-1:StrbWidth] : rq_strb[StrbWidth-1:0];
  assign sel_prot  = load_idx ? rq_prot[5:3] : rq_prot[2:0];
  assign sel_write = rq_write[load_idx];
  assign sel_nse   = rq_nse[load_idx];

  // grant doubles as the round-robin pointer; resetting it to 1 makes requester 0 win first.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= StIdle;
      grant   <= 1'b1;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      pnse    <= 1'b0;
    end else if (load_en) begin
      state   <= StSetup;
      grant   <= load_idx;
      psel    <= 1'b1;
      penable <= 1'b0;
      paddr   <= sel_addr;
      pwrite  <= sel_write;
      pwdata  <= sel_write ? sel_wdata : '0;
      pstrb   <= sel_write ? sel_strb : '0;
      pprot   <= sel_prot;
      pnse    <= sel_nse;
    end else begin
      unique case (state)
        StSetup: begin
          state   <= StAccess;
          penable <= 1'b1;
        end
        StAccess: begin
          if (pready) begin
            state   <= StIdle;
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rq_done   = completing ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rq_rdata  = completing ? prdata : '0;
  assign rq_slverr = completing & pslverr;

`ifdef APB5_ARB_WAKEUP_EN
  logic wake_q;

  // Stay awake while anything is pending or in flight; drop after the final completion.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wake_q <= 1'b0;
    end else begin
      wake_q <= (|(rq_valid & ~rq_done)) || ((state != StIdle) && !completing);
    end
  end

  assign pwakeup = wake_q;
`else
  assign pwakeup = 1'b0;
`endif

endmodule

// File: tb/tb_apb5_arbiter.sv
// Self-checking bench for apb5_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model.
module tb_apb5_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic [1:0] f_valid;
  logic [AW-1:0] f_addr [2];
  logic [DW-1:0] f_wdata [2];
  logic [SW-1:0] f_strb [2];
  logic [2:0] f_prot [2];
  logic [1:0] f_write, f_nse;

  logic [2*AW-1:0] rq_addr;
  logic [2*DW-1:0] rq_wdata;
  logic [2*SW-1:0] rq_strb;
  logic [5:0] rq_prot;
  logic [1:0] rq_done;
  logic [DW-1:0] rq_rdata, pwdata, prdata;
  logic rq_slverr, pnse, psel, penable, pwrite, pready, pslverr, pwakeup;
  logic [AW-1:0] paddr;
  logic [2:0] pprot;
  logic [SW-1:0] pstrb;

  assign rq_addr  = {f_addr[1], f_addr[0]};
  assign rq_wdata = {f_wdata[1], f_wdata[0]};
  assign rq_strb  = {f_strb[1], f_strb[0]};
  assign rq_prot  = {f_prot[1], f_prot[0]};

  apb5_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk(pclk), .preset(preset), .rq_valid(f_valid), .rq_addr(rq_addr), .rq_write(f_write),
    .rq_wdata(rq_wdata), .rq_strb(rq_strb), .rq_prot(rq_prot), .rq_nse(f_nse),
    .rq_done(rq_done), .rq_rdata(rq_rdata), .rq_slverr(rq_slverr), .paddr(paddr),
    .pprot(pprot), .pnse(pnse), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .pwakeup(pwakeup)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: phase 0 = no transfer, 1 = first cycle of a transfer, 2 = later cycles.
  int ph, cur, last;
  logic [1:0] done_prev;
  logic exp_wake;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic [SW-1:0] t_strb;
  logic [2:0] t_prot;
  logic t_write, t_nse;
  logic [1:0] obs_done;
  logic [DW-1:0] obs_rdata, obs_pwdata;
  logic [AW-1:0] obs_paddr;
  logic obs_psel, obs_penable, obs_slverr;

  task automatic new_req(input int n);
    f_valid[n] = 1'b1;
    f_addr[n]  = $urandom;
    f_write[n] = 1'($urandom_range(0, 1));
    f_wdata[n] = $urandom;
    f_strb[n]  = SW'($urandom_range(0, (1 << SW) - 1));
    f_prot[n]  = 3'($urandom_range(0, 7));
    f_nse[n]   = 1'($urandom_range(0, 1));
  endtask

  task automatic take(input int g);
    cur = g;
    last = g;
    t_addr = f_addr[g]; t_write = f_write[g]; t_wdata = f_wdata[g];
    t_strb = f_strb[g]; t_prot = f_prot[g]; t_nse = f_nse[g];
    ph = 1;
  endtask

  // mode 0: random traffic, 1: completed requesters re-request at once, 2: caller drives.
  task automatic cycle(input int mode);
    logic [1:0] exp_done;
    @(negedge pclk);
    if (mode != 2) begin
      for (int n = 0; n < 2; n++) begin
        if (done_prev[n]) begin
          if (mode == 1 || $urandom_range(0, 1) == 1) new_req(n);
          else f_valid[n] = 1'b0;
        end else if (mode == 0 && !f_valid[n]) begin
          if ($urandom_range(0, 3) == 0) new_req(n);
        end else if (mode == 0 && !(ph != 0 && cur == n) && $urandom_range(0, 7) == 0) begin
          f_valid[n] = 1'b0;
        end
      end
      pready  = (mode == 1) || ($urandom_range(0, 2) != 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
    end
    #1;
    exp_done = (ph == 2 && pready) ? 2'(1 << cur) : 2'b00;
    obs_done = rq_done; obs_rdata = rq_rdata; obs_slverr = rq_slverr; obs_psel = psel;
    obs_penable = penable; obs_paddr = paddr; obs_pwdata = pwdata;
    check("psel", psel, ph != 0);
    check("penable", penable, ph == 2);
    check("rq_done", rq_done, exp_done);
    check("rq_rdata", rq_rdata, exp_done != 0 ? prdata : '0);
    check("rq_slverr", rq_slverr, exp_done != 0 && pslverr);
`ifdef APB5_ARB_WAKEUP_EN
    check("pwakeup", pwakeup, exp_wake);
`else
    check("pwakeup", pwakeup, 0);
`endif
    if (ph != 0) begin
      check("paddr", paddr, t_addr);
      check("pwrite", pwrite, t_write);
      check("pwdata", pwdata, t_write ? t_wdata : '0);
      check("pstrb", pstrb, t_write ? t_strb : '0);
      check("pprot", pprot, t_prot);
      check("pnse", pnse, t_nse);
    end
    exp_wake = ((f_valid & ~exp_done) != 0) || (ph != 0 && exp_done == 0);
    done_prev = exp_done;
    if (ph == 0) begin
      if (f_valid == 2'b11) take(1 - last);
      else if (f_valid != 0) take(f_valid[1] ? 1 : 0);
    end else if (ph == 1) begin
      ph = 2;
    end else if (pready) begin
      if (f_valid[1 - cur]) take(1 - cur);
      else ph = 0;
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    ph = 0; last = 1; cur = 0; done_prev = 0; exp_wake = 0;
  endtask

  task automatic do_reset(input bit check_vals);
    preset = 1'b1; f_valid = 0; pready = 0; pslverr = 0; prdata = 0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    if (check_vals) begin
      check("rst_psel", psel, 0);       check("rst_penable", penable, 0);
      check("rst_paddr", paddr, 0);     check("rst_pwrite", pwrite, 0);
      check("rst_pwdata", pwdata, 0);   check("rst_pstrb", pstrb, 0);
      check("rst_pprot", pprot, 0);     check("rst_pnse", pnse, 0);
      check("rst_pwakeup", pwakeup, 0); check("rst_rq_done", rq_done, 0);
    end
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  int order[$];
  int psel_low;

  initial begin
    for (int n = 0; n < 2; n++) begin
      f_addr[n] = 0; f_wdata[n] = 0; f_strb[n] = 0; f_prot[n] = 0;
    end
    f_write = 0; f_nse = 0;
    do_reset(1'b1);

    // Single read from requester 0.
    f_valid[0] = 1'b1; f_addr[0] = 32'h40; f_write[0] = 1'b0; f_prot[0] = 3'd2;
    cycle(2);
    check("r_c0_psel", obs_psel, 0);
    cycle(2);
    check("r_c1_psel", obs_psel, 1); check("r_c1_penable", obs_penable, 0);
    check("r_c1_paddr", obs_paddr, 32'h40);
    pready = 1'b1; prdata = 32'hDEADBEEF;
    cycle(2);
    check("r_c2_done", obs_done, 2'b01); check("r_c2_rdata", obs_rdata, 32'hDEADBEEF);
    f_valid[0] = 1'b0; pready = 1'b0;
    cycle(2);

    // Write from requester 1 with three wait states.
    f_valid[1] = 1'b1; f_addr[1] = 32'h1000; f_write[1] = 1'b1;
    f_wdata[1] = 32'h1234; f_strb[1] = 4'hF;
    cycle(2); cycle(2);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pready = 1'b1;
      cycle(2);
      check("w_paddr", obs_paddr, 32'h1000); check("w_pwdata", obs_pwdata, 32'h1234);
      check("w_done", obs_done, i == 3 ? 2'b10 : 2'b00);
    end
    f_valid[1] = 1'b0; pready = 1'b0;
    cycle(2);

    // Error response.
    f_valid[0] = 1'b1; f_write[0] = 1'b0; pslverr = 1'b1;
    cycle(2); cycle(2);
    check("e_pre_slverr", obs_slverr, 0);
    pready = 1'b1;
    cycle(2);
    check("e_slverr", obs_slverr, 1);
    f_valid[0] = 1'b0; pready = 1'b0; pslverr = 1'b0;
    cycle(2);

    // Reset asserted during the second wait cycle.
    f_valid[0] = 1'b1;
    cycle(2); cycle(2); cycle(2);
    @(negedge pclk);
    preset = 1'b1; pready = 1'b1;
    #1;
    check("ra_psel", psel, 0); check("ra_penable", penable, 0); check("ra_done", rq_done, 0);
    f_valid = 0;
    model_reset();
    @(posedge pclk);
    #1;
    preset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(2);

    // Contention: both requesters continuously valid.
    do_reset(1'b0);
    new_req(0); new_req(1); pready = 1'b1;
    order.delete();
    psel_low = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1);
      if (obs_done != 0) order.push_back(obs_done[1] ? 1 : 0);
      if (i > 0 && !obs_psel) psel_low++;
    end
    check("c_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) check("c_order", order[i], i % 2);
    check("c_psel_low", psel_low, 0);

    // Randomized traffic.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) cycle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb5_arbiter.md
APB5_ARBITER -- requirements
Module: apb5_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width (8, 16 or 32).
REQ-003 pclk  input  1  sole clock; all state on its rising edge.
REQ-004 preset  input  1  reset, asynchronous, active-high.
REQ-005 rq_valid  input  2  per-requester transfer request, bit n = requester n.
REQ-006 rq_addr  input  2*ADDR_WIDTH  per-requester address, slice n = requester n.
REQ-007 rq_write  input  2  per-requester direction (1 = write).
REQ-008 rq_wdata  input  2*DATA_WIDTH  per-requester write data.
REQ-009 rq_strb  input  2*(DATA_WIDTH/8)  per-requester write strobes.
REQ-010 rq_prot  input  6  per-requester PPROT, 3 bits each.
REQ-011 rq_nse  input  2  per-requester PNSE.
REQ-012 rq_done  output  2  one-cycle completion pulse to the granted requester.
REQ-013 rq_rdata  output  DATA_WIDTH  read data, valid only with rq_done.
REQ-014 rq_slverr  output  1  error response, valid only with rq_done.
REQ-015 paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb  output  APB5 requester side, widths per APB5.
REQ-016 pready, prdata, pslverr  input  APB5 completer response.
REQ-017 pwakeup  output  1  APB5 wake-up (see Configuration).

Function
REQ-018 States: IDLE (psel=0, penable=0), SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
REQ-019 IDLE -> SETUP when any rq_valid is high; the grant is decided and all APB request outputs are registered from the granted slices on that edge.
REQ-020 SETUP -> ACCESS unconditionally after one cycle.
REQ-021 ACCESS with pready=0: remain in ACCESS with all outputs held stable.
REQ-022 ACCESS with pready=1: rq_done[grant] is high combinationally that cycle, rq_rdata=prdata, rq_slverr=pslverr.
REQ-023 ACCESS with pready=1 and the other requester's rq_valid high: go directly to SETUP and grant the other requester (no IDLE cycle).
REQ-024 ACCESS with pready=1 and the other requester idle: go to IDLE, even if the completing requester's rq_valid is still high.
REQ-025 Arbitration is round-robin: with both valid in IDLE, grant the requester not granted last; after reset, requester 0 wins.
REQ-026 Requesters hold rq_valid and their fields stable until rq_done, then deassert rq_valid or present a new request no earlier than the next cycle.
REQ-027 rq_done, rq_rdata and rq_slverr are 0 whenever no completion occurs.
REQ-028 pwdata=0 and pstrb=0 for reads.
REQ-029 A rq_valid dropped by a non-granted requester before grant is never issued; a granted transfer always completes.

Reset
REQ-030 preset high forces IDLE immediately, asynchronously, including mid-SETUP or mid-ACCESS.
REQ-031 Reset values: psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, pprot=0, pnse=0, pwakeup=0, rq_done=0, round-robin pointer favours requester 0.
REQ-032 After reset deasserts, an interrupted transfer is not retried and no rq_done is issued for it.

Configuration
REQ-033 Macro APB5_ARB_WAKEUP_EN defined: pwakeup is a registered output, high from the cycle after any rq_valid rises until the cycle after the last completion with no rq_valid pending.
REQ-034 Macro APB5_ARB_WAKEUP_EN undefined: pwakeup is tied to 0 and no wake-up logic is built.

Verification
REQ-035 Single read: rq_valid=01, rq_addr[0]=0x40, pready=1 in the first ACCESS cycle, prdata=0xDEADBEEF -> SETUP at cycle 1, ACCESS at cycle 2, rq_done=01 with rq_rdata=0xDEADBEEF at cycle 2.
REQ-036 Wait states: write from requester 1, wdata=0x1234, strb=0xF, pready low for 3 ACCESS cycles -> paddr and pwdata stable for 4 ACCESS cycles, rq_done=10 in the 4th.
REQ-037 Contention: rq_valid=11 held from reset -> grant order 0,1,0,1; ACCESS goes directly to SETUP with no IDLE cycle; psel stays high throughout.
REQ-038 Error response: pslverr=1 with pready=1 -> rq_slverr=1 only in the rq_done cycle, 0 otherwise.
REQ-039 Reset in ACCESS: assert preset during the 2nd wait cycle -> psel and penable go 0 in the same cycle with no clock edge; no rq_done is issued.
REQ-040 Macro build: with APB5_ARB_WAKEUP_EN defined, pwakeup rises one cycle after rq_valid and falls after the final completion; with it undefined, pwakeup is constant 0.
